// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types, sizes and segment codes for the BCD display path
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   localparam int DATA_W = 16;
   localparam int DIGITS = 5;
   localparam int SR_W   = 4 * DIGITS + DATA_W;

   // Active-low, bit order g..a
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_to_seven_seg.sv
// rtl/bcd_to_seven_seg.sv - combinational BCD digit to active-low seven-segment decoder
module bcd_to_seven_seg
   import disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = blank ? SEG_BLANK : seg_of(digit);
   end

endmodule

// File: rtl/disp_bcd_controller.sv
// rtl/disp_bcd_controller.sv - captures a result, converts it by double-dabble, drives HEX0..HEX4
// Optional: DISP_LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module disp_bcd_controller
   import disp_pkg::*;
(
   input  logic              Clock,
   input  logic              Reset,
   input  logic [DATA_W-1:0] PROC_in,
   input  logic              PROC_done,
   output logic              DISP_busy,
   output logic              DISP_update,
   output logic [6:0]        DISP_out_HEX0,
   output logic [6:0]        DISP_out_HEX1,
   output logic [6:0]        DISP_out_HEX2,
   output logic [6:0]        DISP_out_HEX3,
   output logic [6:0]        DISP_out_HEX4
);

   state_t            state, state_next;
   logic [SR_W-1:0]   sr, sr_adj;
   logic [4:0]        cnt;
   logic [3:0]        digit [DIGITS];
   logic              blank;
   logic              update;
   logic [DIGITS-1:0] digit_blank;
   logic [6:0]        hex [DIGITS];

   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (PROC_done) state_next = SHIFT;
         SHIFT:   if (cnt == 5'(DATA_W - 1)) state_next = LATCH;
         LATCH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      DISP_busy   = (state != IDLE);
      DISP_update = update;
   end

   // Add-3 correction is confined to each nibble; no carry crosses digit boundaries
   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr[DATA_W + 4*i +: 4] >= 4'd5)
            sr_adj[DATA_W + 4*i +: 4] = sr[DATA_W + 4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sr     <= '0;
         cnt    <= '0;
         blank  <= 1'b1;
         update <= 1'b0;
         for (int i = 0; i < DIGITS; i++) digit[i] <= 4'hF;
      end else begin
         update <= 1'b0;
         case (state)
            IDLE: begin
               if (PROC_done) begin
                  sr  <= {{(4*DIGITS){1'b0}}, PROC_in};
                  cnt <= '0;
               end
            end
            SHIFT: begin
               sr  <= sr_adj << 1;
               cnt <= cnt + 5'd1;
            end
            LATCH: begin
               for (int i = 0; i < DIGITS; i++) digit[i] <= sr[DATA_W + 4*i +: 4];
               blank  <= 1'b0;
               update <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef DISP_LEADING_ZERO_BLANK_EN
   logic lead;

   // Mask derives from the committed digits, so it changes only when digits are latched
   always_comb begin
      lead        = 1'b1;
      digit_blank = {DIGITS{blank}};
      for (int k = DIGITS - 1; k >= 1; k--) begin
         lead           = lead & (digit[k] == 4'd0);
         digit_blank[k] = blank | lead;
      end
   end
`else
   always_comb begin
      digit_blank = {DIGITS{blank}};
   end
`endif

   for (genvar k = 0; k < DIGITS; k++) begin : g_seg
      bcd_to_seven_seg u_seg (
         .digit (digit[k]),
         .blank (digit_blank[k]),
         .seg   (hex[k])
      );
   end

   assign DISP_out_HEX0 = hex[0];
   assign DISP_out_HEX1 = hex[1];
   assign DISP_out_HEX2 = hex[2];
   assign DISP_out_HEX3 = hex[3];
   assign DISP_out_HEX4 = hex[4];

endmodule

// File: tb/tb_disp_bcd_controller.sv
// tb/tb_disp_bcd_controller.sv - randomized self-checking bench with a decimal reference model
module tb_disp_bcd_controller;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] PROC_in;
   logic        PROC_done;
   logic        DISP_busy, DISP_update;
   logic [6:0]  DISP_out_HEX0, DISP_out_HEX1, DISP_out_HEX2, DISP_out_HEX3, DISP_out_HEX4;
   logic [6:0]  hex [5];

   int errors = 0;
   int checks = 0;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   int pow10 [5] = '{1, 10, 100, 1000, 10000};
   logic [6:0] shown [5];

   always #5 Clock = ~Clock;

   disp_bcd_controller dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .PROC_in       (PROC_in),
      .PROC_done     (PROC_done),
      .DISP_busy     (DISP_busy),
      .DISP_update   (DISP_update),
      .DISP_out_HEX0 (DISP_out_HEX0),
      .DISP_out_HEX1 (DISP_out_HEX1),
      .DISP_out_HEX2 (DISP_out_HEX2),
      .DISP_out_HEX3 (DISP_out_HEX3),
      .DISP_out_HEX4 (DISP_out_HEX4)
   );

   assign hex[0] = DISP_out_HEX0;
   assign hex[1] = DISP_out_HEX1;
   assign hex[2] = DISP_out_HEX2;
   assign hex[3] = DISP_out_HEX3;
   assign hex[4] = DISP_out_HEX4;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] exp_hex(input int v, input int k);
      int d;
      d = (v / pow10[k]) % 10;
`ifdef DISP_LEADING_ZERO_BLANK_EN
      if (k > 0 && v < pow10[k]) return 7'b1111111;
`endif
      return seg_tab[d];
   endfunction

   task automatic set_model(input int v);
      for (int k = 0; k < 5; k++) shown[k] = exp_hex(v, k);
   endtask

   task automatic check_display(input string tag);
      for (int k = 0; k < 5; k++) check($sformatf("%s_hex%0d", tag, k), int'(hex[k]), int'(shown[k]));
   endtask

   // One conversion of v; optionally pulses PROC_done with v2 at sample pulse_at while busy
   task automatic convert(input string tag, input int v, input int pulse_at, input int v2);
      int busy_cycles, upd_cycles, upd_at;
      busy_cycles = 0;
      upd_cycles  = 0;
      upd_at      = -1;
      @(negedge Clock);
      PROC_in   = 16'(v);
      PROC_done = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge Clock);
         PROC_done = (i == pulse_at);
         if (i == pulse_at) PROC_in = 16'(v2);
         if (DISP_busy) busy_cycles++;
         if (DISP_update) begin
            upd_cycles++;
            if (upd_at < 0) upd_at = i;
         end
         if (i == 8) check_display({tag, "_hold"});
      end
      PROC_done = 1'b0;
      check({tag, "_update_latency"}, upd_at, 17);
      check({tag, "_update_count"}, upd_cycles, 1);
      check({tag, "_busy_cycles"}, busy_cycles, 17);
      set_model(v);
      check_display(tag);
   endtask

   initial begin
      int upd_idx [$];
      int v, ups, hex0_bad;
      bit seen;

      Reset     = 1'b1;
      PROC_in   = '0;
      PROC_done = 1'b0;
      repeat (2) @(negedge Clock);
      for (int k = 0; k < 5; k++) shown[k] = 7'b1111111;
      check_display("reset");
      check("reset_busy", int'(DISP_busy), 0);
      check("reset_update", int'(DISP_update), 0);
      Reset = 1'b0;

      convert("zero", 0, -1, 0);
      convert("max", 65535, -1, 0);
      convert("ignore_busy", 12, 5, 99);

      // Reset during a conversion: nothing is committed, display blanks
      @(negedge Clock);
      PROC_in   = 16'd4660;
      PROC_done = 1'b1;
      ups = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge Clock);
         PROC_done = 1'b0;
         Reset     = (i == 8 || i == 9);
         if (DISP_update) ups++;
      end
      check("abort_update_count", ups, 0);
      check("abort_busy", int'(DISP_busy), 0);
      for (int k = 0; k < 5; k++) shown[k] = 7'b1111111;
      check_display("abort");
      convert("after_abort", 4660, -1, 0);

      // PROC_done held high: back-to-back conversions
      @(negedge Clock);
      PROC_in   = 16'd7;
      PROC_done = 1'b1;
      seen      = 1'b0;
      hex0_bad  = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge Clock);
         if (DISP_update) begin
            upd_idx.push_back(j);
            seen = 1'b1;
         end
         if (seen && hex[0] != 7'b1111000) hex0_bad++;
      end
      PROC_done = 1'b0;
      repeat (20) @(negedge Clock);
      check("b2b_pulses", upd_idx.size(), 2);
      if (upd_idx.size() >= 2) begin
         check("b2b_first", upd_idx[0], 17);
         check("b2b_spacing", upd_idx[1] - upd_idx[0], 18);
      end
      check("b2b_hex0_stable", hex0_bad, 0);
      set_model(7);
      check_display("b2b");

      foreach (pow10[k]) convert($sformatf("pow%0d", k), pow10[k], -1, 0);
      convert("n9999", 9999, -1, 0);
      for (int r = 0; r < 20; r++) begin
         v = int'($urandom_range(0, 65535));
         convert($sformatf("rand%0d_%0d", r, v), v, -1, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
